// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, parser state encoding and key-event record
// used by the key event controller and its event queue.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    BRK  = 2'd2
  } parse_state_e;

  // 10-bit event record; "break" is a keyword, so the release flag is brk
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  function automatic key_evt_t mkEvt(input logic ext, input logic brk, input logic [7:0] code);
    key_evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through queue of key events; head_o is valid whenever empty_o is low.
// A push while full is accepted only if a pop happens in the same cycle.
module key_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  key_evt_t                 push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output key_evt_t                 head_o
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     level_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-byte parser (E0/F0 prefixes, prefix timeout) feeding a FWFT event queue.
// Optional typematic-repeat suppression is built when KEY_REPEAT_FILTER_EN is defined.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        drv_done,
  input  logic [7:0]                  drv_data,
  input  logic                        evt_ready,
  input  logic                        ovf_clr,
  output logic                        evt_valid,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_break,
  output logic                        evt_ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  parse_state_e  state_q;
  logic          brk_ext_q;
  logic [TW-1:0] tmo_q;
  logic          ovf_q;

  logic          raw_emit;
  key_evt_t      raw_evt;
  logic          emit;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          drop;
  key_evt_t      head;

  // Event decode is combinational so the queue write lands on the edge ending the drv_done cycle
  always_comb begin
    raw_emit = 1'b0;
    raw_evt  = mkEvt(1'b0, 1'b0, drv_data);
    if (drv_done) begin
      case (state_q)
        IDLE: begin
          if (drv_data != PS2_EXT && drv_data != PS2_BRK &&
              drv_data != PS2_ERR0 && drv_data != PS2_ERR1) begin
            raw_emit = 1'b1;
          end
        end
        EXT: begin
          if (drv_data != PS2_EXT && drv_data != PS2_BRK) begin
            raw_emit = 1'b1;
            raw_evt  = mkEvt(1'b1, 1'b0, drv_data);
          end
        end
        BRK: begin
          if (drv_data != PS2_EXT && drv_data != PS2_BRK) begin
            raw_emit = 1'b1;
            raw_evt  = mkEvt(brk_ext_q, 1'b1, drv_data);
          end
        end
        default: raw_emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      brk_ext_q <= 1'b0;
      tmo_q     <= '0;
    end else if (drv_done) begin
      tmo_q <= '0;
      case (state_q)
        IDLE: begin
          if (drv_data == PS2_EXT) begin
            state_q <= EXT;
          end else if (drv_data == PS2_BRK) begin
            state_q   <= BRK;
            brk_ext_q <= 1'b0;
          end
        end
        EXT: begin
          if (drv_data == PS2_BRK) begin
            state_q   <= BRK;
            brk_ext_q <= 1'b1;
          end else if (drv_data != PS2_EXT) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // A prefix left dangling for TIMEOUT_CYC quiet cycles is abandoned
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_q <= IDLE;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end else begin
      tmo_q <= '0;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [8:0] last_make_q;
  logic       held_q;
  logic       same_key;

  assign same_key = (last_make_q == {raw_evt.ext, raw_evt.code});

  // Typematic repeats of the held key are swallowed; breaks always pass
  always_comb begin
    emit = raw_emit;
    if (raw_emit && !raw_evt.brk && held_q && same_key) emit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_make_q <= '0;
      held_q      <= 1'b0;
    end else if (raw_emit) begin
      if (!raw_evt.brk) begin
        last_make_q <= {raw_evt.ext, raw_evt.code};
        held_q      <= 1'b1;
      end else if (same_key) begin
        held_q <= 1'b0;
      end
    end
  end
`else
  assign emit = raw_emit;
`endif

  assign pop  = evt_ready && !fifo_empty;
  assign drop = emit && fifo_full && !pop;

  key_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (emit),
    .push_data_i(raw_evt),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level),
    .head_o     (head)
  );

  // A drop in the same cycle as ovf_clr wins, so no overflow is ever lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign evt_valid = !fifo_empty;
  assign evt_code  = fifo_empty ? 8'h00 : head.code;
  assign evt_ext   = !fifo_empty && head.ext;
  assign evt_break = !fifo_empty && head.brk;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Self-checking bench for ps2_key_event_ctrl: table-driven parser vectors, a scoreboard
// of expected events, and hand sequences for latency, timeout, overflow and reset.
module tb_ps2_key_event_ctrl;

  typedef struct {
    logic [7:0] data;
    bit         emit;
    bit         ext;
    bit         brk;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_done = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_ovf;
  logic [3:0] fifo_level;

  int         nChecks = 0;
  int         nFails = 0;
  int         evtCount = 0;
  logic [9:0] sb[$];
  vec_t       vecs[$];

  always #5 clk = ~clk;

  ps2_key_event_ctrl #(
    .FIFO_DEPTH (8),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .drv_done  (drv_done),
    .drv_data  (drv_data),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_ovf   (evt_ovf),
    .fifo_level(fifo_level)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One drv_done pulse; called at posedge+1, returns at the next posedge+1
  task automatic applyStimulus(input logic [7:0] b);
    drv_done = 1'b1;
    drv_data = b;
    @(posedge clk);
    #1;
    drv_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectEvt(input bit ext, input bit brk, input logic [7:0] code);
    sb.push_back({ext, brk, code});
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    drv_done  = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic drainCheck(input string name);
    idle(12);
    checkOutput(name, sb.size(), 0);
    sb.delete();
  endtask

  // Every accepted pop is matched against the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      evtCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected event", {evt_ext, evt_break, evt_code}, 10'h3FF);
      end else begin
        automatic logic [9:0] expEvt = sb.pop_front();
        checkOutput("event {ext,brk,code}", {evt_ext, evt_break, evt_code}, expEvt);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{8'h1C, 1, 0, 0});
    vecs.push_back('{8'hE0, 0, 0, 0});
    vecs.push_back('{8'hF0, 0, 0, 0});
    vecs.push_back('{8'h75, 1, 1, 1});
    vecs.push_back('{8'hF0, 0, 0, 0});
    vecs.push_back('{8'h1C, 1, 0, 1});
    vecs.push_back('{8'hE0, 0, 0, 0});
    vecs.push_back('{8'h74, 1, 1, 0});
    vecs.push_back('{8'h00, 0, 0, 0});
    vecs.push_back('{8'hFF, 0, 0, 0});
    vecs.push_back('{8'hF0, 0, 0, 0});
    vecs.push_back('{8'hE0, 0, 0, 0});
    vecs.push_back('{8'h29, 1, 0, 0});
    vecs.push_back('{8'hE0, 0, 0, 0});
    vecs.push_back('{8'hE0, 0, 0, 0});
    vecs.push_back('{8'h6B, 1, 1, 0});
    vecs.push_back('{8'hE0, 0, 0, 0});
    vecs.push_back('{8'hF0, 0, 0, 0});
    vecs.push_back('{8'hF0, 0, 0, 0});
    vecs.push_back('{8'h33, 1, 0, 0});
    vecs.push_back('{8'hF0, 0, 0, 0});
    vecs.push_back('{8'h00, 1, 0, 1});

    $display("[TB] reset state");
    doReset();
    checkOutput("reset evt_valid", evt_valid, 0);
    checkOutput("reset evt_code", evt_code, 8'h00);
    checkOutput("reset evt_ext", evt_ext, 0);
    checkOutput("reset evt_break", evt_break, 0);
    checkOutput("reset evt_ovf", evt_ovf, 0);
    checkOutput("reset fifo_level", fifo_level, 0);

    $display("[TB] single make latency");
    evt_ready = 1'b1;
    drv_done  = 1'b1;
    drv_data  = 8'h1C;
    expectEvt(0, 0, 8'h1C);
    @(negedge clk);
    checkOutput("valid in drv_done cycle", evt_valid, 0);
    @(posedge clk);
    #1;
    drv_done = 1'b0;
    @(negedge clk);
    checkOutput("valid one cycle later", evt_valid, 1);
    @(negedge clk);
    checkOutput("valid after pop", evt_valid, 0);
    @(posedge clk);
    #1;
    drainCheck("latency scoreboard drained");

    $display("[TB] parser vector table");
    doReset();
    evt_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].emit) expectEvt(vecs[i].ext, vecs[i].brk, vecs[i].data);
      applyStimulus(vecs[i].data);
    end
    drainCheck("table scoreboard drained");

    $display("[TB] prefix timeout");
    doReset();
    evt_ready = 1'b1;
    applyStimulus(8'hE0);
    idle(100);
    expectEvt(0, 0, 8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'hE0);
    idle(99);
    expectEvt(1, 0, 8'h2C);
    applyStimulus(8'h2C);
    applyStimulus(8'hF0);
    idle(100);
    expectEvt(0, 0, 8'h3C);
    applyStimulus(8'h3C);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    idle(100);
    expectEvt(0, 0, 8'h4C);
    applyStimulus(8'h4C);
    drainCheck("timeout scoreboard drained");

    $display("[TB] overflow");
    doReset();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) expectEvt(0, 0, 8'h10 + 8'(k));
      applyStimulus(8'h10 + 8'(k));
    end
    checkOutput("full fifo_level", fifo_level, 8);
    checkOutput("ovf after drop", evt_ovf, 1);
    ovf_clr = 1'b1;
    applyStimulus(8'h19);
    ovf_clr = 1'b0;
    checkOutput("ovf drop beats clear", evt_ovf, 1);
    checkOutput("level after drop", fifo_level, 8);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    checkOutput("ovf cleared", evt_ovf, 0);
    evt_ready = 1'b1;
    expectEvt(0, 0, 8'h20);
    applyStimulus(8'h20);
    checkOutput("level push+pop while full", fifo_level, 8);
    drainCheck("overflow scoreboard drained");
    checkOutput("ovf stays clear", evt_ovf, 0);

    $display("[TB] typematic repeat");
    doReset();
    evt_ready = 1'b1;
    evtCount  = 0;
    expectEvt(0, 0, 8'h1C);
`ifndef KEY_REPEAT_FILTER_EN
    expectEvt(0, 0, 8'h1C);
    expectEvt(0, 0, 8'h1C);
`endif
    expectEvt(0, 1, 8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    idle(6);
`ifdef KEY_REPEAT_FILTER_EN
    checkOutput("repeat event count", evtCount, 2);
`else
    checkOutput("repeat event count", evtCount, 4);
`endif
    drainCheck("repeat scoreboard drained");

    $display("[TB] reset mid-sequence");
    doReset();
    applyStimulus(8'h2A);
    applyStimulus(8'hE0);
    rst_n    = 1'b0;
    drv_done = 1'b1;
    drv_data = 8'h1C;
    idle(1);
    drv_done = 1'b0;
    checkOutput("valid during reset", evt_valid, 0);
    checkOutput("level during reset", fifo_level, 0);
    checkOutput("code during reset", evt_code, 8'h00);
    idle(1);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    expectEvt(0, 0, 8'h1C);
    applyStimulus(8'h1C);
    drainCheck("reset scoreboard drained");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
